// File: rtl/mem_stage.sv
// Purpose : MEM pipeline stage - EX/MEM capture, data-memory req/ack access with watchdog, MEM/WB register.
// Latency : non-memory op 1 cycle to write-back; memory op k cycles (ack on k-th req cycle) plus 1 capture bubble.
// Backpr. : o_MEM_stall holds EXE for the whole access; ack is ignored unless req is high.
//
// Ports
//   clk, rstn                   clock, asynchronous active-low reset
//   i_MEM_*  (EXE side)         dmemWe, regWe, sWD, WRA, aluOut, rd2 from EXE
//   o_MEM_stall                 EXE must hold its outputs while high
//   o_MEM_dmem*/i_MEM_dmem*     data-memory request/ack interface
//   o_MEM_regWe/WRA/WD          registered write-back to the register file
//   o_MEM_err                   one-cycle pulse when an access is aborted by the watchdog
module mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_MEM_dmemWe,
    input  logic        i_MEM_regWe,
    input  logic        i_MEM_sWD,
    input  logic [4:0]  i_MEM_WRA,
    input  logic [31:0] i_MEM_aluOut,
    input  logic [31:0] i_MEM_rd2,
    output logic        o_MEM_stall,
    output logic        o_MEM_dmemReq,
    output logic        o_MEM_dmemWr,
    output logic [31:0] o_MEM_dmemAddr,
    output logic [31:0] o_MEM_dmemWdata,
    input  logic        i_MEM_dmemAck,
    input  logic [31:0] i_MEM_dmemRdata,
    output logic        o_MEM_regWe,
    output logic [4:0]  o_MEM_WRA,
    output logic [31:0] o_MEM_WD,
    output logic        o_MEM_err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state;

    // EX/MEM capture register
    logic        cap_we;
    logic        cap_regwe;
    logic        cap_swd;
    logic [4:0]  cap_wra;
    logic [31:0] cap_alu;
    logic [31:0] cap_rd2;

    logic [15:0] wd_cnt;

    logic        in_memop;
    logic        cap_memop;
    logic        cap_is_load;
    logic        timeout;

    assign in_memop    = i_MEM_dmemWe | i_MEM_sWD;
    assign cap_memop   = cap_we | cap_swd;
    // dmemWe together with sWD behaves as a store, so write-back data is the ALU result.
    assign cap_is_load = cap_swd & ~cap_we;
    assign timeout     = (state == ACCESS) && !i_MEM_dmemAck && (wd_cnt == 16'(TIMEOUT - 1));

    assign o_MEM_stall     = (state == ACCESS);
    assign o_MEM_dmemReq   = (state == ACCESS);
    assign o_MEM_dmemWr    = cap_we;
    assign o_MEM_dmemAddr  = cap_alu;
    assign o_MEM_dmemWdata = cap_rd2;

    // Capture only while not stalled, so request fields stay stable through ACCESS.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cap_we    <= 1'b0;
            cap_regwe <= 1'b0;
            cap_swd   <= 1'b0;
            cap_wra   <= '0;
            cap_alu   <= '0;
            cap_rd2   <= '0;
        end else if (state == IDLE) begin
            cap_we    <= i_MEM_dmemWe;
            cap_regwe <= i_MEM_regWe;
            cap_swd   <= i_MEM_sWD;
            cap_wra   <= i_MEM_WRA;
            cap_alu   <= i_MEM_aluOut;
            cap_rd2   <= i_MEM_rd2;
        end
    end

    // Access FSM, watchdog and MEM/WB register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            wd_cnt      <= '0;
            o_MEM_regWe <= 1'b0;
            o_MEM_WRA   <= '0;
            o_MEM_WD    <= '0;
            o_MEM_err   <= 1'b0;
        end else begin
            o_MEM_err <= 1'b0;
            if (state == IDLE) begin
                // Clearing every idle cycle guarantees a zero count on ACCESS entry.
                wd_cnt <= '0;
                if (in_memop) begin
                    state <= ACCESS;
                end
                if (cap_memop) begin
                    // Memory op already wrote back when its ack arrived.
                    o_MEM_regWe <= 1'b0;
                end else begin
                    o_MEM_regWe <= cap_regwe;
                    o_MEM_WRA   <= cap_wra;
                    o_MEM_WD    <= cap_alu;
                end
            end else begin
                if (i_MEM_dmemAck) begin
                    // Ack wins over a simultaneous watchdog expiry.
                    state       <= IDLE;
                    o_MEM_regWe <= cap_regwe;
                    o_MEM_WRA   <= cap_wra;
                    o_MEM_WD    <= cap_is_load ? i_MEM_dmemRdata : cap_alu;
                end else if (timeout) begin
                    state       <= IDLE;
                    o_MEM_regWe <= 1'b0;
                    o_MEM_err   <= 1'b1;
                end else begin
                    wd_cnt      <= wd_cnt + 16'd1;
                    o_MEM_regWe <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk;
    logic        rstn;
    logic        dmem_we;
    logic        reg_we;
    logic        swd;
    logic [4:0]  wra;
    logic [31:0] alu_out;
    logic [31:0] rd2;
    logic        stall;
    logic        dmem_req;
    logic        dmem_wr;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_we;
    logic [4:0]  wb_wra;
    logic [31:0] wb_wd;
    logic        err;

    int total;
    int bad;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .i_MEM_dmemWe    (dmem_we),
        .i_MEM_regWe     (reg_we),
        .i_MEM_sWD       (swd),
        .i_MEM_WRA       (wra),
        .i_MEM_aluOut    (alu_out),
        .i_MEM_rd2       (rd2),
        .o_MEM_stall     (stall),
        .o_MEM_dmemReq   (dmem_req),
        .o_MEM_dmemWr    (dmem_wr),
        .o_MEM_dmemAddr  (dmem_addr),
        .o_MEM_dmemWdata (dmem_wdata),
        .i_MEM_dmemAck   (dmem_ack),
        .i_MEM_dmemRdata (dmem_rdata),
        .o_MEM_regWe     (wb_we),
        .o_MEM_WRA       (wb_wra),
        .o_MEM_WD        (wb_wd),
        .o_MEM_err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory-side outputs; stall must always mirror req.
    task automatic chk_mem(input string tag, input logic e_req, input logic e_wr,
                           input logic [31:0] e_addr, input logic [31:0] e_wdata);
        chk({tag, ".req"},   32'(dmem_req),  32'(e_req));
        chk({tag, ".stall"}, 32'(stall),     32'(e_req));
        chk({tag, ".wr"},    32'(dmem_wr),   32'(e_wr));
        chk({tag, ".addr"},  dmem_addr,      e_addr);
        chk({tag, ".wdata"}, dmem_wdata,     e_wdata);
    endtask

    task automatic chk_wb(input string tag, input logic e_we, input logic [4:0] e_wra,
                          input logic [31:0] e_wd, input logic e_err);
        chk({tag, ".regWe"}, 32'(wb_we),  32'(e_we));
        chk({tag, ".WRA"},   32'(wb_wra), 32'(e_wra));
        chk({tag, ".WD"},    wb_wd,       e_wd);
        chk({tag, ".err"},   32'(err),    32'(e_err));
    endtask

    // Outputs are sampled and inputs driven 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic rwe, input logic s, input logic [4:0] a,
                         input logic [31:0] alu, input logic [31:0] d);
        dmem_we = we;
        reg_we  = rwe;
        swd     = s;
        wra     = a;
        alu_out = alu;
        rd2     = d;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rstn       = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        drive(0, 0, 0, 0, 0, 0);

        // Reset state
        tick();
        tick();
        chk_mem("rst", 0, 0, 32'h0, 32'h0);
        chk_wb("rst", 0, 0, 32'h0, 0);
        rstn = 1'b1;

        // ALU stream: three back-to-back register writes
        drive(0, 1, 0, 3, 32'h10, 0);
        tick();
        chk_mem("alu0", 0, 0, 32'h10, 32'h0);
        chk_wb("alu0", 0, 0, 32'h0, 0);
        drive(0, 1, 0, 4, 32'h20, 0);
        tick();
        chk_mem("alu1", 0, 0, 32'h20, 32'h0);
        chk_wb("alu1", 1, 3, 32'h10, 0);
        drive(0, 1, 0, 5, 32'h30, 0);
        tick();
        chk_mem("alu2", 0, 0, 32'h30, 32'h0);
        chk_wb("alu2", 1, 4, 32'h20, 0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk_wb("alu3", 1, 5, 32'h30, 0);
        tick();
        chk_wb("alu4", 0, 0, 32'h0, 0);

        // Load with ack on the 3rd req cycle; next instruction held by EXE
        drive(0, 1, 1, 7, 32'h100, 0);
        tick();
        chk_mem("ld_c1", 1, 0, 32'h100, 32'h0);
        chk_wb("ld_c1", 0, 0, 32'h0, 0);
        drive(0, 1, 0, 9, 32'h55, 0);
        tick();
        chk_mem("ld_c2", 1, 0, 32'h100, 32'h0);
        chk_wb("ld_c2", 0, 0, 32'h0, 0);
        tick();
        chk_mem("ld_c3", 1, 0, 32'h100, 32'h0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        tick();
        chk_mem("ld_done", 0, 0, 32'h100, 32'h0);
        chk_wb("ld_done", 1, 7, 32'hDEADBEEF, 0);
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        tick();
        chk_mem("ld_next_cap", 0, 0, 32'h55, 32'h0);
        chk_wb("ld_next_cap", 0, 7, 32'hDEADBEEF, 0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk_wb("ld_next_wb", 1, 9, 32'h55, 0);

        // Store with immediate ack
        drive(1, 0, 0, 0, 32'h40, 32'h12345678);
        tick();
        chk_mem("st_c1", 1, 1, 32'h40, 32'h12345678);
        chk_wb("st_c1", 0, 0, 32'h0, 0);
        drive(0, 0, 0, 0, 0, 0);
        dmem_ack = 1'b1;
        tick();
        chk_mem("st_done", 0, 1, 32'h40, 32'h12345678);
        chk_wb("st_done", 0, 0, 32'h40, 0);
        dmem_ack = 1'b0;
        tick();
        chk_mem("st_after", 0, 0, 32'h0, 32'h0);
        chk_wb("st_after", 0, 0, 32'h40, 0);
        tick();
        chk_wb("st_after2", 0, 0, 32'h0, 0);

        // Timeout: load with ack held low
        drive(0, 1, 1, 11, 32'h200, 0);
        tick();
        chk_mem("to_c1", 1, 0, 32'h200, 32'h0);
        chk_wb("to_c1", 0, 0, 32'h0, 0);
        drive(0, 1, 0, 12, 32'h77, 0);
        tick();
        chk_mem("to_c2", 1, 0, 32'h200, 32'h0);
        chk_wb("to_c2", 0, 0, 32'h0, 0);
        tick();
        chk_mem("to_c3", 1, 0, 32'h200, 32'h0);
        chk_wb("to_c3", 0, 0, 32'h0, 0);
        tick();
        chk_mem("to_c4", 1, 0, 32'h200, 32'h0);
        chk_wb("to_c4", 0, 0, 32'h0, 0);
        tick();
        chk_mem("to_abort", 0, 0, 32'h200, 32'h0);
        chk_wb("to_abort", 0, 0, 32'h0, 1);
        tick();
        chk_mem("to_next_cap", 0, 0, 32'h77, 32'h0);
        chk_wb("to_next_cap", 0, 0, 32'h0, 0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk_wb("to_next_wb", 1, 12, 32'h77, 0);

        // Ack on the 4th req cycle: completes normally, no err
        drive(0, 1, 1, 13, 32'h300, 0);
        tick();
        chk_mem("bd_c1", 1, 0, 32'h300, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk_mem("bd_c2", 1, 0, 32'h300, 32'h0);
        tick();
        chk_mem("bd_c3", 1, 0, 32'h300, 32'h0);
        tick();
        chk_mem("bd_c4", 1, 0, 32'h300, 32'h0);
        chk_wb("bd_c4", 0, 0, 32'h0, 0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        tick();
        chk_mem("bd_done", 0, 0, 32'h300, 32'h0);
        chk_wb("bd_done", 1, 13, 32'hCAFEF00D, 0);
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        tick();
        chk_wb("bd_after", 0, 13, 32'hCAFEF00D, 0);

        // Stray ack while req is low
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0BADBAD0;
        tick();
        chk_mem("stray1", 0, 0, 32'h0, 32'h0);
        chk_wb("stray1", 0, 0, 32'h0, 0);
        tick();
        chk_mem("stray2", 0, 0, 32'h0, 32'h0);
        chk_wb("stray2", 0, 0, 32'h0, 0);
        dmem_ack   = 1'b0;
        dmem_rdata = '0;

        // Reset in the middle of an access
        drive(0, 1, 0, 21, 32'hABC, 0);
        tick();
        chk_wb("mr_pre", 0, 0, 32'h0, 0);
        drive(0, 1, 1, 22, 32'h400, 0);
        tick();
        chk_mem("mr_acc", 1, 0, 32'h400, 32'h0);
        chk_wb("mr_acc", 1, 21, 32'hABC, 0);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        rstn = 1'b0;
        #1;
        chk_mem("mr_rst", 0, 0, 32'h0, 32'h0);
        chk_wb("mr_rst", 0, 0, 32'h0, 0);
        #1;
        rstn = 1'b1;
        tick();
        chk_mem("mr_rel1", 0, 0, 32'h0, 32'h0);
        chk_wb("mr_rel1", 0, 0, 32'h0, 0);
        tick();
        chk_mem("mr_rel2", 0, 0, 32'h0, 32'h0);
        chk_wb("mr_rel2", 0, 0, 32'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage that consumes the EXE stage's outputs and drives the data-memory side of the processor. It holds the EX/MEM pipeline register, performs loads and stores over a req/ack handshake with a watchdog, stalls EXE while an access is outstanding, and presents registered write-back results to the register file. It sits between the EXE stage and the register-file write port.

## Interface
- TIMEOUT, 255: maximum cycles `o_MEM_dmemReq` stays high without ack before the access is aborted; legal range 1..65535.

- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_MEM_dmemWe  in  1  store request from EXE.
- i_MEM_regWe  in  1  register write enable from EXE.
- i_MEM_sWD  in  1  1 = load; write data comes from memory. 0 = write data is the ALU result.
- i_MEM_WRA  in  5  destination register address.
- i_MEM_aluOut  in  32  ALU result; also the memory address.
- i_MEM_rd2  in  32  store data.
- o_MEM_stall  out  1  EXE must hold all its outputs stable while high.
- o_MEM_dmemReq  out  1  memory request.
- o_MEM_dmemWr  out  1  1 = write, 0 = read.
- o_MEM_dmemAddr  out  32  memory address.
- o_MEM_dmemWdata  out  32  store data.
- i_MEM_dmemAck  in  1  memory completion; sampled only while req is high.
- i_MEM_dmemRdata  in  32  read data; valid in the cycle ack is high.
- o_MEM_regWe  out  1  write-back enable.
- o_MEM_WRA  out  5  write-back address.
- o_MEM_WD  out  32  write-back data.
- o_MEM_err  out  1  one-cycle pulse when an access times out.

## Operation
- EX/MEM capture register: loads all six inputs on every rising edge where `o_MEM_stall` = 0.
- memop = captured `dmemWe | sWD`.
- Illegal combination `dmemWe` = `sWD` = 1: treated as a store; `WD` = `aluOut`.
- FSM states:
  - IDLE → ACCESS at a capture edge where the incoming `dmemWe | sWD` = 1.
  - ACCESS → IDLE on an edge where ack = 1.
  - ACCESS → IDLE on timeout.
  - Otherwise the FSM holds its state.
- Outputs driven from state and the capture register:
  - `o_MEM_stall` = (state == ACCESS).
  - `o_MEM_dmemReq` = (state == ACCESS).
  - `o_MEM_dmemWr` = captured `dmemWe`.
  - `o_MEM_dmemAddr` = captured `aluOut`, unmodified; no alignment check.
  - `o_MEM_dmemWdata` = captured `rd2`.
  - All of these are stable for the whole ACCESS period.
- MEM/WB register, loaded on every edge:
  - IDLE with captured non-memop: regWe, WRA from the capture register; WD = `aluOut`.
  - IDLE with captured memop (the instruction already completed): regWe = 0; WRA, WD hold.
  - ACCESS with ack:
    - regWe = captured regWe; WRA = captured WRA.
    - WD = `i_MEM_dmemRdata` for a load, `aluOut` for a store.
  - ACCESS with timeout: regWe = 0; `o_MEM_err` = 1 for one cycle.
  - ACCESS, neither ack nor timeout: regWe = 0.
- Watchdog counter:
  - Cleared on entry to ACCESS.
  - Increments each ACCESS cycle without ack.
  - Timeout = the counter reaches TIMEOUT−1 with ack low, i.e. TIMEOUT req-high cycles without ack.
  - Ack in the same cycle as the timeout condition: ack wins, so the access completes normally with no err.
- Ack while req is low is ignored.

## Timing
- Reset (asynchronous, immediate): state IDLE; capture register, counter and all outputs 0. Req therefore drops mid-access; the memory must tolerate an abandoned request.
- Non-memory instruction:
  - Captured at edge N; WB outputs valid after edge N+1.
  - Throughput 1 per cycle; stall never asserted.
- Memory instruction:
  - Captured at edge N; req and stall high from edge N.
  - Ack sampled at edge N+k (k ≥ 1); WB valid and req/stall low after edge N+k.
  - The next instruction is captured at edge N+k+1.
  - Minimum cost: 2 cycles.
- WB outputs are registered; regWe is high for exactly one cycle per completing instruction.

## Test plan
- Reset mid-access: assert rstn = 0 while req = 1 → req, stall and all outputs 0 immediately; after release, state IDLE and no write-back.
- ALU stream: three back-to-back instructions `regWe`=1, WRA = 3/4/5, aluOut = 0x10/0x20/0x30 → stall stays 0; `o_MEM_regWe` high for 3 consecutive cycles with matching WRA/WD, each one cycle after capture.
- Load with 3-cycle memory latency: sWD=1, regWe=1, WRA=7, aluOut=0x100; ack with rdata 0xDEADBEEF on the 3rd req cycle →
  - req high with addr 0x100, Wr=0, for exactly 3 cycles;
  - stall high for the same 3 cycles;
  - WB: WRA=7, WD=0xDEADBEEF, regWe high for one cycle;
  - the EXE-held instruction is captured one cycle later.
- Store with immediate ack: dmemWe=1, aluOut=0x40, rd2=0x12345678, ack on the first req cycle →
  - one req cycle with Wr=1, addr 0x40, wdata 0x12345678;
  - `o_MEM_regWe` stays 0.
- Timeout: TIMEOUT=4, load with ack held low →
  - req high for exactly 4 cycles, then `o_MEM_err` pulses 1 cycle;
  - regWe stays 0;
  - the next instruction proceeds normally.
- Ack at the timeout boundary: TIMEOUT=4, ack asserted on the 4th req cycle → normal completion, err stays 0. Also drive a stray ack with req = 0 → no effect.
